// File: rtl/weight_buf_stream.sv
// weight_buf_stream: one weight matrix buffer (Wq/Wk/Wv/Wo). It holds a
// synchronous RAM with a byte-enabled host write port and a burst-read
// engine. The engine streams consecutive words over valid/ready and fully
// supports back-pressure.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_en/wr_addr/wr_data/wr_be host write, per-byte enables
//   rd_start/rd_base/rd_len     burst request (sampled in IDLE only)
//   rd_busy, rd_done            burst in progress / one-cycle completion pulse
//   rd_valid/rd_ready/rd_data/rd_last  output stream
module weight_buf_stream #(
  parameter int    WIDTH     = 64,
  parameter int    DEPTH     = 4096,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter int    LEN_W     = ADDR_W + 1,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rd_start,
  input  logic [ADDR_W-1:0]  rd_base,
  input  logic [LEN_W-1:0]   rd_len,
  output logic               rd_busy,
  output logic               rd_done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_last
);
  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;      // reads still to issue
  logic               infl_vld_q, infl_last_q;
  logic [WIDTH-1:0]   ram_rdata_q;
  logic               out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               done_q, done_d;
  logic               pop, issue, issue_last;
  logic [2:0]         pending;

  assign pop        = out_vld_q & rd_ready;
  assign issue_last = (cnt_q == LEN_W'(1));
  // Words that will still occupy storage after this cycle. A word popped
  // now frees its slot in time for a read issued now, so full rate is
  // sustained with only two storage entries.
  assign pending    = 3'(infl_vld_q) + 3'(out_vld_q) + 3'(skid_vld_q) - 3'(pop);

  // Memory: read-first on same-address collision (NBA read of the old word).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
    if (issue) ram_rdata_q <= mem[addr_q];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_len != '0) begin
            state_d = RUN;
            addr_d  = rd_base;
            cnt_d   = rd_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pending < 3'd2) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;  // wraps modulo DEPTH
          cnt_d  = cnt_q - 1'b1;
          if (issue_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry skid: out_* drives the port, skid_* catches a landing word
  // while the consumer stalls. The skid drains into out before new data.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = infl_vld_q;
        skid_data_d = ram_rdata_q;
        skid_last_d = infl_last_q;
      end else if (infl_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = ram_rdata_q;
        out_last_d = infl_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;  // data deliberately held
      end
    end else if (infl_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = ram_rdata_q;
      skid_last_d = infl_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      infl_vld_q  <= 1'b0;
      infl_last_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      infl_vld_q  <= issue;
      infl_last_q <= issue & issue_last;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
      done_q      <= done_d;
    end
  end

  assign rd_busy  = (state_q != IDLE);
  assign rd_done  = done_q;
  assign rd_valid = out_vld_q;
  assign rd_data  = out_data_q;
  assign rd_last  = out_last_q;
endmodule

// File: tb/tb_weight_buf_stream.sv
module tb_weight_buf_stream;
  localparam int WIDTH  = 64;
  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [7:0]        wr_be;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_base;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_busy, rd_done, rd_valid, rd_ready, rd_last;
  logic [WIDTH-1:0]  rd_data;

  logic [63:0] model [DEPTH];
  int checks   = 0;
  int failures = 0;

  weight_buf_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic do_write(input int a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
  endtask

  // mode 0: rd_ready held high (latency/throughput checked)
  // mode 1: 1,0,0,1 ready pattern then random stalls
  // inj: a second rd_start is raised mid-burst and must be ignored
  task automatic burst(input int base, input int len, input int mode, input bit inj);
    int idx = 0, first = -1, last_acc = -1, budget;
    bit pv = 0, pr = 0, done_seen = 0;
    logic [63:0] pd = '0, exp_last = '0;
    logic pl = 0;
    budget = len * 4 + 40;
    rd_base = ADDR_W'(base); rd_len = LEN_W'(len); rd_start = 1'b1;
    rd_ready = (mode == 0);
    @(negedge clk);
    for (int it = 1; it < budget; it++) begin
      if (inj && it == 5) begin
        rd_start = 1'b1; rd_base = ADDR_W'(100); rd_len = LEN_W'(3);
      end else rd_start = 1'b0;
      if (mode == 0) rd_ready = 1'b1;
      else if (it <= 16) rd_ready = (it % 4 == 0) || (it % 4 == 3);
      else rd_ready = 1'($urandom_range(0, 1));
      if (pv && !pr) begin
        check("hold_valid", 64'(rd_valid), 64'd1);
        check("hold_data", rd_data, pd);
        check("hold_last", 64'(rd_last), 64'(pl));
      end
      if (rd_done) begin
        check("done_count", 64'(idx), 64'(len));
        check("done_timing", 64'(it), 64'(last_acc + 1));
        check("busy_fall", 64'(rd_busy), 64'd0);
        check("valid_after_done", 64'(rd_valid), 64'd0);
        check("data_held", rd_data, exp_last);
        done_seen = 1;
        break;
      end
      if (rd_valid) begin
        if (first < 0) begin
          first = it;
          if (mode == 0) check("first_latency", 64'(it), 64'd3);
        end
        if (rd_ready) begin
          check("extra_word", 64'(idx < len), 64'd1);
          check("data", rd_data, model[(base + idx) % DEPTH]);
          check("last", 64'(rd_last), 64'(idx == len - 1));
          if (mode == 0) check("no_bubble", 64'(it), 64'(first + idx));
          exp_last = model[(base + idx) % DEPTH];
          last_acc = it;
          idx++;
        end
      end
      pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
      @(negedge clk);
    end
    rd_start = 1'b0;
    check("done_seen", 64'(done_seen), 64'd1);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_done", 64'(rd_done), 64'd0);
    check("rst_last", 64'(rd_last), 64'd0);
    check("rst_data", rd_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 16; a++) do_write(a, 64'(a) * 64'h0101_0101_0101_0101, 8'hFF);
    do_write(DEPTH - 2, 64'hA5A5_0000_0000_FFFE, 8'hFF);
    do_write(DEPTH - 1, 64'hA5A5_0000_0000_FFFF, 8'hFF);

    // Full-rate burst, then stalled burst, then wrap-around burst
    burst(0, 16, 0, 0);
    burst(0, 16, 1, 0);
    burst(DEPTH - 2, 4, 0, 0);

    // Byte-enable merge
    do_write(20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(20, 64'h0, 8'h0F);
    check("be_model", model[20], 64'hFFFF_FFFF_0000_0000);
    burst(20, 1, 0, 0);

    // Read-during-write to the word being fetched returns the old value
    rd_base = ADDR_W'(5); rd_len = LEN_W'(1); rd_start = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = 64'hDEAD_BEEF_CAFE_F00D; wr_be = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("rdw_valid", 64'(rd_valid), 64'd1);
    check("rdw_old_data", rd_data, 64'h0505_0505_0505_0505);
    @(negedge clk);
    check("rdw_done", 64'(rd_done), 64'd1);
    model[5] = 64'hDEAD_BEEF_CAFE_F00D;
    burst(5, 1, 0, 0);

    // Zero-length request: done pulse only
    rd_base = '0; rd_len = '0; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("len0_done", 64'(rd_done), 64'd1);
    check("len0_busy", 64'(rd_busy), 64'd0);
    check("len0_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    check("len0_done_once", 64'(rd_done), 64'd0);
    check("len0_valid2", 64'(rd_valid), 64'd0);

    // Start during active burst is ignored
    burst(0, 16, 0, 1);

    // Reset mid-burst after 5 words
    rd_base = '0; rd_len = LEN_W'(16); rd_start = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    acc = 0;
    for (int it = 1; it < 40 && acc < 5; it++) begin
      if (rd_valid) acc++;
      @(negedge clk);
    end
    check("mid_words", 64'(acc), 64'd5);
    check("mid_valid_pre", 64'(rd_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_busy", 64'(rd_busy), 64'd0);
    check("mid_rst_last", 64'(rd_last), 64'd0);
    check("mid_rst_data", rd_data, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 64'(rd_done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 64'(rd_done), 64'd0);
    burst(8, 4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
